i2c_slave: RTL and testbench

I2C_SLAVE -- requirements
Module: i2c_slave

---
 rtl/i2c_slave.sv | 203 ++++++++++++++++++++
 tb/tb_i2c_slave.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// I2C target with a 7-bit address. It oversamples SCL/SDA on clk, ACKs writes
// and serves reads through an open-drain SDA.
module i2c_slave #(
   parameter logic [6:0] DEV_ADDR = 7'h42
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl,
   inout  wire        sda,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_load,
   output logic       addressed,
   output logic       read_mode
);
   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_WAIT_STOP
   } state_t;

   state_t     r_state, w_state_next;
   logic [2:0] r_scl_sync, r_sda_sync;
   logic [2:0] r_bit_cnt, w_bit_cnt_next;
   logic [6:0] r_shift, w_shift_next;
   logic [6:0] r_tx_shift, w_tx_shift_next;
   logic       r_sda_low, w_sda_low_next;
   logic       r_ack_on, w_ack_on_next;
   logic [7:0] r_rx_data, w_rx_data_next;
   logic       r_rx_valid, w_rx_valid_next;
   logic       r_tx_load, w_tx_load_next;
   logic       r_addressed, w_addressed_next;
   logic       r_read_mode, w_read_mode_next;

   logic       w_scl_rise, w_scl_fall, w_scl_hi, w_start, w_stop, w_sda_in;
   logic [7:0] w_shift_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scl_sync <= 3'b111;
         r_sda_sync <= 3'b111;
      end else begin
         r_scl_sync <= {r_scl_sync[1:0], scl};
         r_sda_sync <= {r_sda_sync[1:0], sda};
      end
   end

   // Edges and bus conditions compare stage 2 (newer) against stage 3 (older)
   assign w_scl_rise = r_scl_sync[1] & ~r_scl_sync[2];
   assign w_scl_fall = ~r_scl_sync[1] & r_scl_sync[2];
   assign w_scl_hi   = r_scl_sync[1] & r_scl_sync[2];
   assign w_start    = w_scl_hi & r_sda_sync[2] & ~r_sda_sync[1];
   assign w_stop     = w_scl_hi & ~r_sda_sync[2] & r_sda_sync[1];
   assign w_sda_in   = r_sda_sync[1];
   assign w_shift_in = {r_shift, w_sda_in};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_bit_cnt   <= 3'd0;
         r_shift     <= 7'd0;
         r_tx_shift  <= 7'd0;
         r_sda_low   <= 1'b0;
         r_ack_on    <= 1'b0;
         r_rx_data   <= 8'h00;
         r_rx_valid  <= 1'b0;
         r_tx_load   <= 1'b0;
         r_addressed <= 1'b0;
         r_read_mode <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_bit_cnt   <= w_bit_cnt_next;
         r_shift     <= w_shift_next;
         r_tx_shift  <= w_tx_shift_next;
         r_sda_low   <= w_sda_low_next;
         r_ack_on    <= w_ack_on_next;
         r_rx_data   <= w_rx_data_next;
         r_rx_valid  <= w_rx_valid_next;
         r_tx_load   <= w_tx_load_next;
         r_addressed <= w_addressed_next;
         r_read_mode <= w_read_mode_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_bit_cnt_next   = r_bit_cnt;
      w_shift_next     = r_shift;
      w_tx_shift_next  = r_tx_shift;
      w_sda_low_next   = r_sda_low;
      w_ack_on_next    = r_ack_on;
      w_rx_data_next   = r_rx_data;
      w_rx_valid_next  = 1'b0;
      w_tx_load_next   = 1'b0;
      w_addressed_next = r_addressed;
      w_read_mode_next = r_read_mode;
      if (w_start) begin
         w_state_next     = S_ADDR;
         w_bit_cnt_next   = 3'd0;
         w_sda_low_next   = 1'b0;
         w_ack_on_next    = 1'b0;
         w_addressed_next = 1'b0;
      end else if (w_stop) begin
         w_state_next     = S_IDLE;
         w_sda_low_next   = 1'b0;
         w_addressed_next = 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_WAIT_STOP: ;
            S_ADDR: if (w_scl_rise) begin
               w_shift_next   = w_shift_in[6:0];
               w_bit_cnt_next = r_bit_cnt + 3'd1;
               if (r_bit_cnt == 3'd7) begin
                  if (w_shift_in[7:1] == DEV_ADDR) begin
                     w_read_mode_next = w_shift_in[0];
                     w_ack_on_next    = 1'b0;
                     w_state_next     = S_ADDR_ACK;
                  end else begin
                     w_state_next = S_WAIT_STOP;
                  end
               end
            end
            // First falling edge starts the ACK, the second ends it
            S_ADDR_ACK: if (w_scl_fall) begin
               if (!r_ack_on) begin
                  w_sda_low_next   = 1'b1;
                  w_addressed_next = 1'b1;
                  w_ack_on_next    = 1'b1;
               end else begin
                  w_ack_on_next  = 1'b0;
                  w_bit_cnt_next = 3'd0;
                  if (r_read_mode) begin
                     w_tx_shift_next = tx_data[6:0];
                     w_tx_load_next  = 1'b1;
                     w_sda_low_next  = ~tx_data[7];
                     w_state_next    = S_READ;
                  end else begin
                     w_sda_low_next = 1'b0;
                     w_state_next   = S_WRITE;
                  end
               end
            end
            S_WRITE: if (w_scl_rise) begin
               w_shift_next   = w_shift_in[6:0];
               w_bit_cnt_next = r_bit_cnt + 3'd1;
               if (r_bit_cnt == 3'd7) begin
                  w_rx_data_next  = w_shift_in;
                  w_rx_valid_next = 1'b1;
                  w_ack_on_next   = 1'b0;
                  w_state_next    = S_WRITE_ACK;
               end
            end
            S_WRITE_ACK: if (w_scl_fall) begin
               if (!r_ack_on) begin
                  w_sda_low_next = 1'b1;
                  w_ack_on_next  = 1'b1;
               end else begin
                  w_sda_low_next = 1'b0;
                  w_ack_on_next  = 1'b0;
                  w_bit_cnt_next = 3'd0;
                  w_state_next   = S_WRITE;
               end
            end
            S_READ: if (w_scl_fall) begin
               if (r_bit_cnt == 3'd7) begin
                  w_sda_low_next = 1'b0;
                  w_ack_on_next  = 1'b0;
                  w_state_next   = S_READ_ACK;
               end else begin
                  w_bit_cnt_next  = r_bit_cnt + 3'd1;
                  w_sda_low_next  = ~r_tx_shift[6];
                  w_tx_shift_next = {r_tx_shift[5:0], 1'b0};
               end
            end
            // r_ack_on here marks a master ACK awaiting the falling edge that reloads
            S_READ_ACK: begin
               if (w_scl_rise && !r_ack_on) begin
                  if (!w_sda_in) begin
                     w_ack_on_next = 1'b1;
                  end else begin
                     w_addressed_next = 1'b0;
                     w_state_next     = S_WAIT_STOP;
                  end
               end else if (w_scl_fall && r_ack_on) begin
                  w_ack_on_next   = 1'b0;
                  w_bit_cnt_next  = 3'd0;
                  w_tx_shift_next = tx_data[6:0];
                  w_tx_load_next  = 1'b1;
                  w_sda_low_next  = ~tx_data[7];
                  w_state_next    = S_READ;
               end
            end
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   assign sda       = r_sda_low ? 1'b0 : 1'bz;
   assign rx_data   = r_rx_data;
   assign rx_valid  = r_rx_valid;
   assign tx_load   = r_tx_load;
   assign addressed = r_addressed;
   assign read_mode = r_read_mode;
endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged master drives SCL/SDA, and a
// negedge monitor counts pulses and DUT-driven lows on SDA.
module tb_i2c_slave;
   localparam int Q = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl = 1'b1;
   logic       m_low = 1'b0;
   logic [7:0] tx_data = 8'h00;
   wire        sda;
   wire  [7:0] rx_data;
   wire        rx_valid, tx_load, addressed, read_mode;

   int n_checks = 0;
   int n_fail = 0;
   int rx_cnt = 0, tx_cnt = 0, overlap_cnt = 0, stray_cnt = 0, dut_low_cnt = 0, addr_cnt = 0;

   pullup (sda);
   assign sda = m_low ? 1'b0 : 1'bz;

   i2c_slave #(.DEV_ADDR(7'h42)) dut (
      .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda),
      .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
      .tx_load(tx_load), .addressed(addressed), .read_mode(read_mode)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_valid) rx_cnt++;
      if (tx_load) tx_cnt++;
      if (rx_valid && tx_load) overlap_cnt++;
      if ((rx_valid || tx_load) && !addressed) stray_cnt++;
      if (sda === 1'b0 && !m_low) dut_low_cnt++;
      if (addressed) addr_cnt++;
   end

   task automatic wq(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One SCL cycle starting just after SCL fell; returns the line level mid-high
   task automatic bitx(input logic b, output logic line);
      wq(Q); m_low = ~b;
      wq(Q); scl = 1'b1;
      wq(Q); line = (sda === 1'b0) ? 1'b0 : 1'b1;
      wq(Q); scl = 1'b0;
   endtask

   task automatic i2c_start();
      wq(Q); m_low = 1'b1;
      wq(Q); scl = 1'b0;
   endtask

   task automatic i2c_rstart();
      wq(Q); m_low = 1'b0;
      wq(Q); scl = 1'b1;
      wq(Q); m_low = 1'b1;
      wq(Q); scl = 1'b0;
   endtask

   task automatic i2c_stop();
      wq(Q); m_low = 1'b1;
      wq(Q); scl = 1'b1;
      wq(Q); m_low = 1'b0;
      wq(2 * Q);
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      logic l;
      for (int i = 7; i >= 0; i--) bitx(d[i], l);
      bitx(1'b1, ack);
   endtask

   task automatic recv_byte(output logic [7:0] d);
      logic l;
      for (int i = 7; i >= 0; i--) begin
         bitx(1'b1, l);
         d[i] = l;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      wq(3);
      n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
      n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
      n_checks++; if (tx_load !== 1'b0) begin n_fail++; $display("FAIL reset_tx_load got=%b exp=0", tx_load); end
      n_checks++; if (addressed !== 1'b0) begin n_fail++; $display("FAIL reset_addressed got=%b exp=0", addressed); end
      n_checks++; if (read_mode !== 1'b0) begin n_fail++; $display("FAIL reset_read_mode got=%b exp=0", read_mode); end
      n_checks++; if (sda !== 1'b1) begin n_fail++; $display("FAIL reset_sda got=%b exp=1", sda); end
      rst_n = 1'b1;
      wq(4);
      $display("reset: rx_data=%h addressed=%b sda=%b", rx_data, addressed, sda);
   endtask

   task automatic test_write();
      logic a1, a2, addr_mid, rm;
      int rx0;
      rx0 = rx_cnt;
      i2c_start();
      send_byte(8'h84, a1);
      addr_mid = addressed; rm = read_mode;
      send_byte(8'hA5, a2);
      i2c_stop();
      n_checks++; if (a1 !== 1'b0) begin n_fail++; $display("FAIL write_addr_ack got=%b exp=0", a1); end
      n_checks++; if (a2 !== 1'b0) begin n_fail++; $display("FAIL write_data_ack got=%b exp=0", a2); end
      n_checks++; if (addr_mid !== 1'b1) begin n_fail++; $display("FAIL write_addressed got=%b exp=1", addr_mid); end
      n_checks++; if (rm !== 1'b0) begin n_fail++; $display("FAIL write_read_mode got=%b exp=0", rm); end
      n_checks++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL write_rx_data got=%h exp=a5", rx_data); end
      n_checks++; if (rx_cnt - rx0 !== 1) begin n_fail++; $display("FAIL write_rx_pulses got=%0d exp=1", rx_cnt - rx0); end
      n_checks++; if (addressed !== 1'b0) begin n_fail++; $display("FAIL write_addressed_after_stop got=%b exp=0", addressed); end
      $display("write: 0x84 ack=%b data 0xA5 ack=%b rx_data=%h", a1, a2, rx_data);
   endtask

   task automatic test_read();
      logic a, nack, rm;
      logic [7:0] d;
      int tx0;
      tx0 = tx_cnt;
      tx_data = 8'h3C;
      i2c_start();
      send_byte(8'h85, a);
      rm = read_mode;
      recv_byte(d);
      bitx(1'b1, nack);
      n_checks++; if (addressed !== 1'b0) begin n_fail++; $display("FAIL read_addressed_after_nack got=%b exp=0", addressed); end
      i2c_stop();
      n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL read_addr_ack got=%b exp=0", a); end
      n_checks++; if (rm !== 1'b1) begin n_fail++; $display("FAIL read_read_mode got=%b exp=1", rm); end
      n_checks++; if (d !== 8'h3C) begin n_fail++; $display("FAIL read_byte got=%h exp=3c", d); end
      n_checks++; if (nack !== 1'b1) begin n_fail++; $display("FAIL read_sda_released got=%b exp=1", nack); end
      n_checks++; if (tx_cnt - tx0 !== 1) begin n_fail++; $display("FAIL read_tx_pulses got=%0d exp=1", tx_cnt - tx0); end
      $display("read: 0x85 ack=%b byte=%h ack_slot=%b", a, d, nack);
   endtask

   task automatic test_read_continue();
      logic a, l;
      logic [7:0] d1, d2;
      int tx0;
      tx0 = tx_cnt;
      tx_data = 8'h3C;
      i2c_start();
      send_byte(8'h85, a);
      recv_byte(d1);
      tx_data = 8'hC3;
      bitx(1'b0, l);
      recv_byte(d2);
      bitx(1'b1, l);
      i2c_stop();
      n_checks++; if (d1 !== 8'h3C) begin n_fail++; $display("FAIL cont_byte1 got=%h exp=3c", d1); end
      n_checks++; if (d2 !== 8'hC3) begin n_fail++; $display("FAIL cont_byte2 got=%h exp=c3", d2); end
      n_checks++; if (tx_cnt - tx0 !== 2) begin n_fail++; $display("FAIL cont_tx_pulses got=%0d exp=2", tx_cnt - tx0); end
      $display("read_continue: bytes %h %h", d1, d2);
   endtask

   task automatic test_mismatch();
      logic a1, a2;
      int rx0, tx0, low0, ad0;
      rx0 = rx_cnt; tx0 = tx_cnt; low0 = dut_low_cnt; ad0 = addr_cnt;
      i2c_start();
      send_byte(8'h86, a1);
      send_byte(8'hFF, a2);
      i2c_stop();
      n_checks++; if (a1 !== 1'b1) begin n_fail++; $display("FAIL mismatch_addr_ack got=%b exp=1", a1); end
      n_checks++; if (a2 !== 1'b1) begin n_fail++; $display("FAIL mismatch_data_ack got=%b exp=1", a2); end
      n_checks++; if (dut_low_cnt - low0 !== 0) begin n_fail++; $display("FAIL mismatch_sda_driven got=%0d exp=0", dut_low_cnt - low0); end
      n_checks++; if ((rx_cnt - rx0) + (tx_cnt - tx0) !== 0) begin n_fail++; $display("FAIL mismatch_pulses got=%0d exp=0", (rx_cnt - rx0) + (tx_cnt - tx0)); end
      n_checks++; if (addr_cnt - ad0 !== 0) begin n_fail++; $display("FAIL mismatch_addressed got=%0d exp=0", addr_cnt - ad0); end
      $display("mismatch: 0x86 ack=%b data ack=%b", a1, a2);
   endtask

   task automatic test_rstart();
      logic a1, a2, a3, rm1, rm2, l;
      logic [7:0] d;
      int rx0;
      rx0 = rx_cnt;
      i2c_start();
      send_byte(8'h84, a1);
      rm1 = read_mode;
      send_byte(8'h10, a2);
      tx_data = 8'h5A;
      i2c_rstart();
      send_byte(8'h85, a3);
      rm2 = read_mode;
      recv_byte(d);
      bitx(1'b1, l);
      i2c_stop();
      n_checks++; if ({a1, a2, a3} !== 3'b000) begin n_fail++; $display("FAIL rstart_acks got=%b exp=000", {a1, a2, a3}); end
      n_checks++; if ({rm1, rm2} !== 2'b01) begin n_fail++; $display("FAIL rstart_read_mode got=%b exp=01", {rm1, rm2}); end
      n_checks++; if (rx_cnt - rx0 !== 1) begin n_fail++; $display("FAIL rstart_rx_pulses got=%0d exp=1", rx_cnt - rx0); end
      n_checks++; if (rx_data !== 8'h10) begin n_fail++; $display("FAIL rstart_rx_data got=%h exp=10", rx_data); end
      n_checks++; if (d !== 8'h5A) begin n_fail++; $display("FAIL rstart_read_byte got=%h exp=5a", d); end
      $display("rstart: wrote %h read %h read_mode %b->%b", rx_data, d, rm1, rm2);
   endtask

   task automatic test_abort_stop();
      logic a, l;
      int rx0;
      rx0 = rx_cnt;
      i2c_start();
      send_byte(8'h84, a);
      bitx(1'b1, l); bitx(1'b0, l); bitx(1'b1, l); bitx(1'b1, l);
      i2c_stop();
      n_checks++; if (rx_cnt - rx0 !== 0) begin n_fail++; $display("FAIL abort_stop_rx_pulses got=%0d exp=0", rx_cnt - rx0); end
      n_checks++; if (addressed !== 1'b0) begin n_fail++; $display("FAIL abort_stop_addressed got=%b exp=0", addressed); end
      n_checks++; if (sda !== 1'b1) begin n_fail++; $display("FAIL abort_stop_sda got=%b exp=1", sda); end
      i2c_start();
      send_byte(8'h84, a);
      send_byte(8'h5C, l);
      i2c_stop();
      n_checks++; if ({a, l} !== 2'b00) begin n_fail++; $display("FAIL abort_stop_next_acks got=%b exp=00", {a, l}); end
      n_checks++; if (rx_data !== 8'h5C) begin n_fail++; $display("FAIL abort_stop_next_rx got=%h exp=5c", rx_data); end
      $display("abort_stop: next write rx_data=%h", rx_data);
   endtask

   task automatic test_abort_reset();
      logic a, l, pre;
      int rx0, low0;
      tx_data = 8'h00;
      i2c_start();
      send_byte(8'h85, a);
      wq(2 * Q);
      pre = sda;
      rst_n = 1'b0;
      #1;
      n_checks++; if (pre !== 1'b0) begin n_fail++; $display("FAIL abort_rst_driving got=%b exp=0", pre); end
      n_checks++; if (sda !== 1'b1) begin n_fail++; $display("FAIL abort_rst_sda got=%b exp=1", sda); end
      n_checks++; if (addressed !== 1'b0) begin n_fail++; $display("FAIL abort_rst_addressed got=%b exp=0", addressed); end
      wq(3);
      rst_n = 1'b1;
      rx0 = rx_cnt; low0 = dut_low_cnt;
      for (int i = 0; i < 9; i++) bitx(1'b0, l);
      bitx(1'b1, l);
      n_checks++; if (dut_low_cnt - low0 !== 0) begin n_fail++; $display("FAIL abort_rst_ignored got=%0d exp=0", dut_low_cnt - low0); end
      n_checks++; if (rx_cnt - rx0 !== 0) begin n_fail++; $display("FAIL abort_rst_rx_pulses got=%0d exp=0", rx_cnt - rx0); end
      i2c_stop();
      i2c_start();
      send_byte(8'h84, a);
      send_byte(8'h3E, l);
      i2c_stop();
      n_checks++; if ({a, l} !== 2'b00) begin n_fail++; $display("FAIL abort_rst_next_acks got=%b exp=00", {a, l}); end
      n_checks++; if (rx_data !== 8'h3E) begin n_fail++; $display("FAIL abort_rst_next_rx got=%h exp=3e", rx_data); end
      $display("abort_reset: next write rx_data=%h", rx_data);
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_read_continue();
      test_mismatch();
      test_rstart();
      test_abort_stop();
      test_abort_reset();
      n_checks++; if (overlap_cnt !== 0) begin n_fail++; $display("FAIL pulse_overlap got=%0d exp=0", overlap_cnt); end
      n_checks++; if (stray_cnt !== 0) begin n_fail++; $display("FAIL pulse_unaddressed got=%0d exp=0", stray_cnt); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
